// File: rtl/riscv_pkg.sv
// Shared core-wide constants used by datapath blocks.
package riscv_pkg;
   localparam int unsigned XLEN = 32;
endpackage

// File: rtl/elastic_stage.sv
// One elastic slot: a main register backed by a skid register so that the
// upstream ready is a registered flag with no path from the downstream ready.
module elastic_stage #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   logic             main_v, skid_v, main_v_n, skid_v_n;
   logic [WIDTH-1:0] main_d, skid_d, main_d_n, skid_d_n;
   logic             in_fire, out_fire;

   // Reset masks both handshakes so nothing transfers while rst_i is high.
   assign in_ready_o  = ~skid_v & ~rst_i;
   assign out_valid_o = main_v & ~rst_i;
   assign out_data_o  = main_d;
   assign busy_o      = main_v | skid_v;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   // Next-state: skid refills main on consume; flush drops words but keeps data.
   always_comb begin
      main_v_n = main_v;
      skid_v_n = skid_v;
      main_d_n = main_d;
      skid_d_n = skid_d;
      if (flush_i) begin
         main_v_n = 1'b0;
         skid_v_n = 1'b0;
      end else if (out_fire) begin
         if (skid_v) begin
            main_d_n = skid_d;
            skid_v_n = 1'b0;
         end else if (in_fire) begin
            main_d_n = in_data_i;
         end else begin
            main_v_n = 1'b0;
         end
      end else if (in_fire) begin
         if (!main_v) begin
            main_v_n = 1'b1;
            main_d_n = in_data_i;
         end else begin
            skid_v_n = 1'b1;
            skid_d_n = in_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_d <= RESET_VAL;
         skid_d <= RESET_VAL;
      end else begin
         main_v <= main_v_n;
         skid_v <= skid_v_n;
         main_d <= main_d_n;
         skid_d <= skid_d_n;
      end
   end

endmodule

// File: rtl/elastic_reg.sv
// Flow-controlled pipeline register: STAGES cascaded elastic slots, strict
// FIFO order, 2*STAGES words of capacity, flush and synchronous reset.
module elastic_reg
   import riscv_pkg::*;
#(
   parameter int unsigned      WIDTH     = XLEN,
   parameter int unsigned      STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("elastic_reg: STAGES must be in 1..8");
   end

   logic [STAGES:0]   link_valid;
   logic [STAGES:0]   link_ready;
   logic [WIDTH-1:0]  link_data [STAGES+1];
   logic [STAGES-1:0] stage_busy;

   assign link_valid[0]      = in_valid_i;
   assign link_data[0]       = in_data_i;
   assign in_ready_o         = link_ready[0];
   assign out_valid_o        = link_valid[STAGES];
   assign out_data_o         = link_data[STAGES];
   assign link_ready[STAGES] = out_ready_i;

   // Stage k output feeds stage k+1 input.
   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      elastic_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .flush_i     (flush_i),
         .in_valid_i  (link_valid[k]),
         .in_data_i   (link_data[k]),
         .in_ready_o  (link_ready[k]),
         .out_valid_o (link_valid[k+1]),
         .out_data_o  (link_data[k+1]),
         .out_ready_i (link_ready[k+1]),
         .busy_o      (stage_busy[k])
      );
   end

   assign busy_o = |stage_busy;

endmodule

// File: tb/tb_elastic_reg.sv
// Directed and randomised checks of elastic_reg with STAGES=2 (instance a)
// and STAGES=1 (instance b).
module tb_elastic_reg;

   localparam logic [31:0] RV_A = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [31:0] a_in_data, a_out_data;
   logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [31:0] b_in_data, b_out_data;

   int tests = 0;
   int fails = 0;

   elastic_reg #(.WIDTH(32), .STAGES(2), .RESET_VAL(RV_A)) dut_a (
      .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush),
      .in_valid_i(a_in_valid), .in_data_i(a_in_data), .in_ready_o(a_in_ready),
      .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(a_out_ready),
      .busy_o(a_busy));

   elastic_reg #(.WIDTH(32), .STAGES(1), .RESET_VAL(32'h0)) dut_b (
      .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush),
      .in_valid_i(b_in_valid), .in_data_i(b_in_data), .in_ready_o(b_in_ready),
      .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_ready_i(b_out_ready),
      .busy_o(b_busy));

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk); #1;
         tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
         tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
         tests++; if (a_out_data !== RV_A) begin fails++; $display("FAIL reset_out_data: got %h expected %h", a_out_data, RV_A); end
         tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
      end
      @(negedge clk); a_rst = 1'b0; #1;
      tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", a_in_ready); end
   endtask

   // Sends one word into a and checks it appears STAGES=2 sampled cycles later.
   task automatic send_and_check_latency(input logic [31:0] w);
      int lat;
      @(negedge clk); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = w;
      @(negedge clk); a_in_valid = 1'b0; lat = 1;
      while (!a_out_valid && lat < 8) begin @(negedge clk); lat++; end
      tests++; if (lat !== 2) begin fails++; $display("FAIL latency: got %0d cycles expected 2", lat); end
      tests++; if (a_out_data !== w) begin fails++; $display("FAIL first_word_data: got %h expected %h", a_out_data, w); end
      a_out_ready = 1'b1;
      @(negedge clk); #1;
      tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL first_word_drain_busy: got %b expected 0", a_busy); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_first_word();
      send_and_check_latency(32'h1);
   endtask

   task automatic test_streaming();
      @(negedge clk); b_rst = 1'b0; b_out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); b_in_valid = 1'b1; b_in_data = 32'(i); #1;
         tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, b_in_ready); end
         if (i > 0) begin
            tests++;
            if (b_out_valid !== 1'b1 || b_out_data !== 32'(i - 1)) begin
               fails++; $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, b_out_valid, b_out_data, 32'(i - 1));
            end
         end
      end
      @(negedge clk); b_in_valid = 1'b0; #1;
      tests++; if (b_out_valid !== 1'b1 || b_out_data !== 32'd99) begin fails++; $display("FAIL stream_last: got v=%b d=%h expected v=1 d=63", b_out_valid, b_out_data); end
      @(negedge clk); #1;
      tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL stream_idle_busy: got %b expected 0", b_busy); end
   endtask

   // Presents words 'base+n' with out_ready low until in_ready drops; returns count accepted.
   task automatic fill_a(input logic [31:0] base, input int max_words, output int accepted);
      accepted = 0;
      a_out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (accepted >= max_words) begin a_in_valid = 1'b0; break; end
         a_in_valid = 1'b1; a_in_data = base + 32'(accepted);
         #1;
         if (a_in_ready) accepted++;
      end
      @(negedge clk); a_in_valid = 1'b0;
   endtask

   task automatic test_back_pressure();
      int acc;
      logic exp_rdy [4];
      exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b1;
      fill_a(32'h100, 100, acc);
      #1;
      tests++; if (acc !== 4) begin fails++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
      tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b expected 0", a_in_ready); end
      tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL bp_full_busy: got %b expected 1", a_busy); end
      a_out_ready = 1'b1; #1;
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (a_out_valid !== 1'b1 || a_out_data !== 32'h100 + 32'(j)) begin
            fails++; $display("FAIL bp_drain[%0d]: got v=%b d=%h expected v=1 d=%h", j, a_out_valid, a_out_data, 32'h100 + 32'(j));
         end
         tests++; if (a_in_ready !== exp_rdy[j]) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected %b", j, a_in_ready, exp_rdy[j]); end
         @(negedge clk); #1;
      end
      tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL bp_empty_busy: got %b expected 0", a_busy); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_flush_collision();
      int acc;
      bit seen;
      fill_a(32'h200, 3, acc);
      #1;
      tests++; if (acc !== 3 || a_in_ready !== 1'b1) begin fails++; $display("FAIL flush_setup: got acc=%0d rdy=%b expected acc=3 rdy=1", acc, a_in_ready); end
      a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hAA;
      @(negedge clk); a_flush = 1'b0; a_in_valid = 1'b0; #1;
      tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b expected 0", a_busy); end
      tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b expected 0", a_out_valid); end
      tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b expected 1", a_in_ready); end
      a_out_ready = 1'b1; seen = 1'b0;
      repeat (6) begin @(negedge clk); #1; if (a_out_valid) seen = 1'b1; end
      tests++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_word_leaked: got out_valid seen=%b expected 0", seen); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      logic [31:0] exp, prev_data;
      bit hold_prev = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if (hold_prev) begin
            tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== prev_data) begin
               fails++; $display("FAIL rand_stable@%0d: got v=%b d=%h expected v=1 d=%h", c, a_out_valid, a_out_data, prev_data);
            end
         end
         a_in_valid = 1'($urandom_range(0, 1)); a_in_data = $urandom; a_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (a_in_valid && a_in_ready) q.push_back(a_in_data);
         if (a_out_valid && a_out_ready) begin
            tests++;
            if (q.size() == 0) begin fails++; $display("FAIL rand_dup@%0d: got d=%h expected no word", c, a_out_data); end
            else begin
               exp = q.pop_front();
               if (a_out_data !== exp) begin fails++; $display("FAIL rand_order@%0d: got %h expected %h", c, a_out_data, exp); end
            end
         end
         hold_prev = a_out_valid && !a_out_ready;
         prev_data = a_out_data;
      end
      @(negedge clk); a_in_valid = 1'b0; a_out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (a_out_valid && q.size() != 0) begin
            exp = q.pop_front();
            tests++; if (a_out_data !== exp) begin fails++; $display("FAIL rand_drain: got %h expected %h", a_out_data, exp); end
         end
         @(negedge clk);
      end
      #1;
      tests++; if (q.size() != 0 || a_busy !== 1'b0) begin fails++; $display("FAIL rand_loss: got left=%0d busy=%b expected 0 0", q.size(), a_busy); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      int acc;
      fill_a(32'h300, 100, acc);
      a_rst = 1'b1; #1;
      tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_gate: got rdy=%b v=%b expected 0 0", a_in_ready, a_out_valid); end
      @(negedge clk); a_rst = 1'b0; #1;
      tests++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_empty: got busy=%b v=%b expected 0 0", a_busy, a_out_valid); end
      tests++; if (a_out_data !== RV_A) begin fails++; $display("FAIL rst_mid_data: got %h expected %h", a_out_data, RV_A); end
      tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", a_in_ready); end
      send_and_check_latency(32'h55);
   endtask

   initial begin
      a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      test_reset();
      test_first_word();
      test_streaming();
      test_back_pressure();
      test_flush_collision();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
